// File: rtl/seeg_record_ctrl_if.sv
// Conversion request/done handshake between the sEEG record sequencer (master)
// and the ADC front end (slave).
interface seeg_record_ctrl_if #(
    parameter int CH_W = 3
);
    logic            conv_req;
    logic [CH_W-1:0] conv_ch;
    logic            conv_done;

    modport master (output conv_req, output conv_ch, input conv_done);
    modport slave  (input conv_req, input conv_ch, output conv_done);
endinterface

// File: rtl/seeg_record_ctrl.sv
// sEEG recording sequencer: turns start/stop pulses into a periodic frame schedule,
// walking the enabled channels in ascending order over a req/done handshake.
module seeg_record_ctrl #(
    parameter int NUM_CH  = 8,
    parameter int CH_W    = 3,
    parameter int DIV_W   = 16,
    parameter int FRAME_W = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                record_start_i,
    input  logic                record_stop_i,
    input  logic [DIV_W-1:0]    sample_div_i,
    input  logic [NUM_CH-1:0]   ch_enable_i,
    seeg_record_ctrl_if.master  adc_if,
    output logic                recording_o,
    output logic                frame_start_o,
    output logic                frame_done_o,
    output logic [FRAME_W-1:0]  frame_count_o,
    output logic                overrun_o,
    output logic                timeout_err_o
);
    localparam int TO_W = $clog2(TIMEOUT + 1);

    // ST_RUN is the between-frames wait while a session is active.
    typedef enum logic [2:0] {
        ST_IDLE        = 3'd0,
        ST_FRAME_START = 3'd1,
        ST_REQ         = 3'd2,
        ST_GAP         = 3'd3,
        ST_STOPPING    = 3'd4,
        ST_RUN         = 3'd5
    } state_t;

    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_cnt_q;
    logic [NUM_CH-1:0]  pend_q;
    logic [TO_W-1:0]    to_q;
    logic               recording_q;
    logic               frame_start_q;
    logic               frame_done_q;
    logic [FRAME_W-1:0] frame_count_q;
    logic               overrun_q;
    logic               timeout_err_q;
    logic               conv_req_q;
    logic [CH_W-1:0]    conv_ch_q;

    logic               start_acc_d;
    logic               div_run_d;
    logic               tick_d;
    logic               to_hit_d;
    logic               hs_end_d;
    logic [NUM_CH-1:0]  pend_next_d;

    function automatic logic [CH_W-1:0] lowest_ch(input logic [NUM_CH-1:0] mask);
        logic [CH_W-1:0] idx;
        idx = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CH_W'(i);
            end
        end
        return idx;
    endfunction

    // Start acceptance, frame tick, timeout hit and remaining-channel mask.
    always_comb begin
        start_acc_d = (state_q == ST_IDLE) && record_start_i && !record_stop_i;
        div_run_d   = recording_q && (state_q != ST_STOPPING);
        tick_d      = div_run_d && (div_cnt_q == div_q);
        to_hit_d    = (to_q == TO_W'(TIMEOUT - 1));
        hs_end_d    = adc_if.conv_done || to_hit_d;
        pend_next_d = pend_q & ~(NUM_CH'(1) << conv_ch_q);
    end

    // Frame-period divider: 0..div_q, tick on the terminal count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q <= '0;
        end else if (start_acc_d || tick_d) begin
            div_cnt_q <= '0;
        end else if (div_run_d) begin
            div_cnt_q <= div_cnt_q + DIV_W'(1);
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            div_q         <= '0;
            pend_q        <= '0;
            to_q          <= '0;
            recording_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_count_q <= '0;
            overrun_q     <= 1'b0;
            timeout_err_q <= 1'b0;
            conv_req_q    <= 1'b0;
            conv_ch_q     <= '0;
        end else begin
            frame_start_q <= 1'b0;
            frame_done_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_acc_d) begin
                        div_q         <= sample_div_i;
                        frame_count_q <= '0;
                        overrun_q     <= 1'b0;
                        timeout_err_q <= 1'b0;
                        recording_q   <= 1'b1;
                        frame_start_q <= 1'b1;
                        state_q       <= ST_FRAME_START;
                    end
                end
                ST_FRAME_START: begin
                    if (tick_d) begin
                        overrun_q <= 1'b1;
                    end
                    if (record_stop_i) begin
                        recording_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (ch_enable_i == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        pend_q     <= ch_enable_i;
                        conv_ch_q  <= lowest_ch(ch_enable_i);
                        conv_req_q <= 1'b1;
                        to_q       <= '0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (tick_d) begin
                        overrun_q <= 1'b1;
                    end
                    if (hs_end_d) begin
                        conv_req_q <= 1'b0;
                        if (!adc_if.conv_done) begin
                            timeout_err_q <= 1'b1;
                        end
                        if (record_stop_i) begin
                            recording_q <= 1'b0;
                            state_q     <= ST_IDLE;
                        end else begin
                            pend_q  <= pend_next_d;
                            state_q <= ST_GAP;
                            if (pend_next_d == '0) begin
                                frame_done_q  <= 1'b1;
                                frame_count_q <= frame_count_q + FRAME_W'(1);
                            end
                        end
                    end else begin
                        to_q <= to_q + TO_W'(1);
                        if (record_stop_i) begin
                            state_q <= ST_STOPPING;
                        end
                    end
                end
                ST_GAP: begin
                    if (tick_d) begin
                        overrun_q <= 1'b1;
                    end
                    if (record_stop_i) begin
                        recording_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (pend_q != '0) begin
                        conv_ch_q  <= lowest_ch(pend_q);
                        conv_req_q <= 1'b1;
                        to_q       <= '0;
                        state_q    <= ST_REQ;
                    end else begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (record_stop_i) begin
                        recording_q <= 1'b0;
                        state_q     <= ST_IDLE;
                    end else if (tick_d) begin
                        frame_start_q <= 1'b1;
                        state_q       <= ST_FRAME_START;
                    end
                end
                // Let the outstanding conversion finish, then drop the session.
                ST_STOPPING: begin
                    if (hs_end_d) begin
                        conv_req_q  <= 1'b0;
                        recording_q <= 1'b0;
                        state_q     <= ST_IDLE;
                        if (!adc_if.conv_done) begin
                            timeout_err_q <= 1'b1;
                        end
                    end else begin
                        to_q <= to_q + TO_W'(1);
                    end
                end
                default: begin
                    conv_req_q  <= 1'b0;
                    recording_q <= 1'b0;
                    state_q     <= ST_IDLE;
                end
            endcase
        end
    end

    assign adc_if.conv_req = conv_req_q;
    assign adc_if.conv_ch  = conv_ch_q;
    assign recording_o     = recording_q;
    assign frame_start_o   = frame_start_q;
    assign frame_done_o    = frame_done_q;
    assign frame_count_o   = frame_count_q;
    assign overrun_o       = overrun_q;
    assign timeout_err_o   = timeout_err_q;
endmodule

// File: tb/tb_seeg_record_ctrl.sv
// Self-checking bench for seeg_record_ctrl: table-driven sessions plus hand-written
// corner sequences; expected channel order is queued at each frame start.
`timescale 1ns/1ps
module tb_seeg_record_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic        record_start, record_stop;
    logic [15:0] sample_div;
    logic [7:0]  ch_enable;
    logic        recording, frame_start, frame_done, overrun, timeout_err;
    logic [31:0] frame_count;

    seeg_record_ctrl_if #(.CH_W(3)) adc();

    seeg_record_ctrl dut (
        .clk(clk), .rst(rst),
        .record_start_i(record_start), .record_stop_i(record_stop),
        .sample_div_i(sample_div), .ch_enable_i(ch_enable),
        .adc_if(adc),
        .recording_o(recording), .frame_start_o(frame_start), .frame_done_o(frame_done),
        .frame_count_o(frame_count), .overrun_o(overrun), .timeout_err_o(timeout_err)
    );

    always #13 clk = ~clk;

    typedef struct {
        int       div;
        logic [7:0] en;
        int       dly;
        int       frames;
        int       ecount;
        bit       eovr;
        bit       spur;
    } vec_t;
    vec_t vecs[5];

    int n_cmp = 0, n_err = 0;
    int exp_ch_q[$];
    int cyc = 0, last_fs = -1, cur_div = 0, fs_cnt = 0, fd_cnt = 0, low_run = 0, req_age = 0;
    int done_dly = 1, hang_ch = -1, e, n, fs0, fd0;
    bit per_chk = 1'b0, spurious = 1'b0, req_prev = 1'b0, fs_prev = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: push expected channels at each frame start, pop on each new request.
    task automatic monitor();
        cyc++;
        if (frame_start) begin
            fs_cnt++;
            check("fs_queue_empty", exp_ch_q.size(), 0);
            if (per_chk && last_fs >= 0) check("frame_period", cyc - last_fs, cur_div + 1);
            last_fs = cyc;
            for (int c = 0; c < 8; c++) if (ch_enable[c]) exp_ch_q.push_back(c);
        end
        if (adc.conv_req && !req_prev) begin
            check("req_pending", exp_ch_q.size() > 0, 1);
            if (exp_ch_q.size() > 0) begin
                e = exp_ch_q.pop_front();
                check("conv_ch", adc.conv_ch, e);
            end
            if (!fs_prev) check("gap_len", low_run, 1);
        end
        if (frame_done) begin
            fd_cnt++;
            check("fd_queue_empty", exp_ch_q.size(), 0);
            check("fd_req_low", adc.conv_req, 0);
        end
        low_run  = adc.conv_req ? 0 : low_run + 1;
        req_prev = adc.conv_req;
        fs_prev  = frame_start;
    endtask

    task automatic respond();
        if (adc.conv_req) begin
            req_age++;
            adc.conv_done = (req_age == done_dly) && (int'(adc.conv_ch) != hang_ch);
        end else begin
            req_age = 0;
            adc.conv_done = spurious;
        end
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        respond();
        #1;
    endtask

    task automatic new_session(input int div);
        exp_ch_q.delete();
        last_fs = -1;
        cur_div = div;
        sample_div = 16'(div);
    endtask

    task automatic pulse_start();
        record_start = 1'b1; step(); record_start = 1'b0;
    endtask

    task automatic pulse_stop();
        record_stop = 1'b1; step(); record_stop = 1'b0;
    endtask

    task automatic wait_fs(input int target, input int budget, input string name);
        int k = 0;
        while (fs_cnt < target && k < budget) begin step(); k++; end
        check(name, fs_cnt >= target, 1);
    endtask

    task automatic run_vec(input vec_t v);
        new_session(v.div);
        per_chk = !v.eovr; done_dly = v.dly; spurious = v.spur; ch_enable = v.en;
        fs0 = fs_cnt; fd0 = fd_cnt;
        pulse_start();
        check("rec_on", recording, 1);
        check("first_fs", frame_start, 1);
        wait_fs(fs0 + v.frames + 1, (v.div + 1) * (v.frames + 2) + 100, "wait_frames");
        check("frame_count", frame_count, v.ecount);
        check("fd_pulses", fd_cnt - fd0, v.ecount);
        check("overrun", overrun, v.eovr);
        check("timeout_err", timeout_err, 0);
        pulse_stop();
        check("rec_off", recording, 0);
        check("count_hold", frame_count, v.ecount);
        spurious = 1'b0;
        exp_ch_q.delete();
    endtask

    initial begin
        rst = 1'b1; record_start = 1'b0; record_stop = 1'b0;
        sample_div = 16'd0; ch_enable = 8'h00;
        vecs[0] = '{99,  8'h05, 2, 3, 3, 1'b0, 1'b0};
        vecs[1] = '{99,  8'h81, 1, 2, 2, 1'b0, 1'b1};
        vecs[2] = '{49,  8'h00, 1, 3, 0, 1'b0, 1'b0};
        vecs[3] = '{3,   8'hFF, 1, 3, 3, 1'b1, 1'b0};
        vecs[4] = '{199, 8'h3C, 5, 2, 2, 1'b0, 1'b0};

        repeat (3) step();
        rst = 1'b0;
        step();
        check("rst_conv_req", adc.conv_req, 0);
        check("rst_conv_ch", adc.conv_ch, 0);
        check("rst_recording", recording, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_frame_done", frame_done, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout_err", timeout_err, 0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i]);

        // Channel 1 never answers: request must drop after 255 clocks.
        new_session(999); per_chk = 1'b1; done_dly = 2; hang_ch = 1; ch_enable = 8'h06;
        fd0 = fd_cnt;
        pulse_start();
        n = 0;
        while (!(adc.conv_req && adc.conv_ch == 3'd1) && n < 50) begin step(); n++; end
        check("to_ch1_seen", adc.conv_req, 1);
        n = 0;
        while (adc.conv_req && n < 400) begin n++; step(); end
        check("to_req_len", n, 255);
        check("to_err_set", timeout_err, 1);
        n = 0;
        while (fd_cnt == fd0 && n < 50) begin step(); n++; end
        check("to_frame_done", fd_cnt - fd0, 1);
        check("to_frame_count", frame_count, 1);
        pulse_stop();
        hang_ch = -1;
        check("to_rec_off", recording, 0);
        check("to_err_hold", timeout_err, 1);

        // Stop while channel 3 is requested.
        new_session(999); done_dly = 4; ch_enable = 8'hFF;
        fd0 = fd_cnt;
        pulse_start();
        n = 0;
        while (!(adc.conv_req && adc.conv_ch == 3'd3) && n < 100) begin step(); n++; end
        check("stop_ch3_seen", adc.conv_ch, 3);
        pulse_stop();
        check("stop_req_held", adc.conv_req, 1);
        check("stop_rec_held", recording, 1);
        n = 0;
        while (adc.conv_req && n < 300) begin step(); n++; end
        check("stop_rec_off", recording, 0);
        repeat (20) step();
        check("stop_no_more_req", exp_ch_q.size(), 4);
        check("stop_no_frame_done", fd_cnt - fd0, 0);
        check("stop_count_hold", frame_count, 0);
        exp_ch_q.delete();

        // Start and stop together in IDLE.
        fs0 = fs_cnt;
        record_start = 1'b1; record_stop = 1'b1; step();
        record_start = 1'b0; record_stop = 1'b0;
        repeat (3) step();
        check("both_rec_off", recording, 0);
        check("both_no_frame", fs_cnt - fs0, 0);

        // Start while recording must not restart or re-latch the divider.
        new_session(49); done_dly = 1; ch_enable = 8'h01;
        fs0 = fs_cnt;
        pulse_start();
        wait_fs(fs0 + 3, 300, "restart_wait1");
        check("restart_count_pre", frame_count, 2);
        sample_div = 16'd9;
        pulse_start();
        wait_fs(fs0 + 4, 200, "restart_wait2");
        check("restart_count_post", frame_count, 3);
        pulse_stop();
        exp_ch_q.delete();

        // Asynchronous reset in the middle of a conversion.
        new_session(3); per_chk = 1'b0; done_dly = 1; ch_enable = 8'hFF;
        fs0 = fs_cnt;
        pulse_start();
        wait_fs(fs0 + 3, 200, "rst_wait");
        check("rst_pre_overrun", overrun, 1);
        n = 0;
        while (!adc.conv_req && n < 10) begin step(); n++; end
        check("rst_pre_req", adc.conv_req, 1);
        rst = 1'b1;
        #1;
        check("arst_conv_req", adc.conv_req, 0);
        check("arst_recording", recording, 0);
        check("arst_frame_count", frame_count, 0);
        check("arst_overrun", overrun, 0);
        check("arst_timeout_err", timeout_err, 0);
        step();
        rst = 1'b0;
        exp_ch_q.delete();
        run_vec(vecs[0]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/seeg_record_ctrl.md
Name: seeg_record_ctrl

Overview:
Recording sequencer for the sEEG acquisition path, running in the 39 MHz system domain. It converts record_start/record_stop pulses into a periodic sampling schedule. Each frame period it walks the enabled channels in ascending order and issues one conversion request per channel over a req/done handshake to the ADC front end. It also reports frame timing, frame count and error flags.

Parameters:
NUM_CH, 8, number of acquisition channels
CH_W, 3, width of channel index (clog2 NUM_CH)
DIV_W, 16, width of frame-period divider
FRAME_W, 32, width of frame counter
TIMEOUT, 255, max clocks to wait for conv_done per request

Ports:
clk  in  1  system clock (39 MHz)
rst  in  1  reset; one clock; reset is asynchronous and active-high
record_start  in  1  start request, level sampled each clk
record_stop  in  1  stop request, level sampled each clk
sample_div  in  DIV_W  frame period minus 1, in clocks; latched at start
ch_enable  in  NUM_CH  channel enable mask; latched at each frame start
conv_req  out  1  conversion request to front end
conv_ch  out  CH_W  channel index for conv_req
conv_done  in  1  front-end completion strobe
recording  out  1  high while session active (RUN or STOPPING)
frame_start  out  1  one-cycle pulse when a frame begins
frame_done  out  1  one-cycle pulse when the last conversion of a frame completes
frame_count  out  FRAME_W  completed frames since last start
overrun  out  1  sticky: frame tick arrived while a frame was in progress
timeout_err  out  1  sticky: a conversion timed out

Behaviour:
- Reset (async): state IDLE. All outputs 0. Divider, snapshot and timeout counters cleared. Reset mid-conversion drops conv_req immediately.
- States: IDLE, FRAME_START, REQ, GAP, STOPPING.
- IDLE: record_start=1 and record_stop=0 -> latch sample_div, clear frame_count/overrun/timeout_err, clear divider, go FRAME_START. A start and stop in the same cycle -> stay IDLE. record_stop alone is ignored.
- Divider: runs whenever recording=1 and state is not STOPPING. It counts 0..div_latched; tick when count==div_latched, then reloads 0. The first frame begins on the cycle after start is accepted. Frame period = div_latched+1 clocks.
- FRAME_START (1 cycle):
  - frame_start=1, snapshot ch_enable.
  - Snapshot all zero -> no conversions, no frame_done, no frame_count increment; wait for next tick.
  - Otherwise go REQ on the lowest enabled channel.
- REQ:
  - conv_req=1, conv_ch stable until conv_done is sampled 1.
  - conv_req deasserts on the following cycle, then GAP for exactly 1 cycle (conv_req=0).
  - After GAP: next enabled channel (REQ), or end of frame.
  - End of frame: frame_done pulses on the cycle after the last conv_done is sampled, and frame_count increments that cycle (wraps at 2^FRAME_W).
  - conv_done while conv_req=0 is ignored.
- Timeout: TIMEOUT clocks in REQ without conv_done -> drop conv_req, set timeout_err, continue with the next channel as if done. A timed-out channel still counts toward frame completion.
- Tick while a frame is in progress (FRAME_START/REQ/GAP): set overrun and discard the tick. The current frame continues; the next frame waits for the following tick.
- Tick while idle-in-RUN: go FRAME_START.
- record_stop=1 while recording:
  - In REQ: go STOPPING. Finish the outstanding handshake (done or timeout), issue no further channels, no frame_done, then IDLE.
  - Elsewhere: go IDLE next cycle.
  - recording falls on entry to IDLE. Sticky flags and frame_count hold until the next start.
- record_start while recording is ignored.
- sample_div and ch_enable changes take effect only at their latch points.

Test Plan:
- sample_div=99, ch_enable=8'h05, conv_done 2 clks after conv_req -> conv_ch 0 then 2, one GAP cycle between; frame_start every 100 clks; frame_count=3 after 3 frames; overrun=0.
- sample_div=3, ch_enable=8'hFF, conv_done after 1 clk -> overrun=1 within first frame; frame_count increments once per completed 8-channel frame; no frame restarted mid-sequence.
- ch_enable=8'h06, conv_done never returned for ch1 -> conv_req drops after 255 clks, timeout_err=1, ch2 requested after GAP, frame_done pulses after ch2 done.
- Stop asserted while conv_req on ch3 of 8'hFF frame -> no ch4 request, recording=0 one cycle after ch3 conv_done, frame_count unchanged, no frame_done.
- record_start and record_stop high same cycle in IDLE -> recording stays 0. Start while recording -> frame_count not cleared.
- rst pulsed while conv_req=1 -> conv_req, recording, frame_count, overrun, timeout_err all 0 asynchronously; new start runs normally.
